keyed_heap_sorter: RTL and testbench
====================================

KEYED_HEAP_SORTER -- requirements
Module: keyed_heap_sorter

Interface
REQ-001 SHALL have parameter DATA_ADDR_BITS, default 13, meaning RAM address width; maximum record count 2^DATA_ADDR_BITS.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning record width in bits.
REQ-003 SHALL have parameter KEY_WIDTH, default 32, meaning sort-key width; KEY_WIDTH <= DATA_WIDTH.
REQ-004 SHALL have parameter KEY_LSB, default 0, meaning key bit offset within a record; KEY_LSB+KEY_WIDTH <= DATA_WIDTH.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1, synchronous, active-high.
REQ-006 SHALL have ports: start in 1, begin sort; num_values in DATA_ADDR_BITS+1, record count; descending in 1, order select, sampled at start.
REQ-007 SHALL have ports: abort in 1, cancel the sort in progress.
REQ-008 SHALL have port A outputs: we_a 1, waddr_a DATA_ADDR_BITS, wdata_a DATA_WIDTH, raddr_a DATA_ADDR_BITS; port A input rdata_a DATA_WIDTH.
REQ-009 SHALL have port B outputs and input identical in shape to port A (we_b, waddr_b, wdata_b, raddr_b, rdata_b).
REQ-010 SHALL have outputs: busy 1; done 1, one-cycle pulse; aborted 1, one-cycle pulse; progress DATA_ADDR_BITS+1, current heap size.

Function
REQ-011 SHALL treat the RAM as synchronous-read: rdata_x is valid in the second cycle after the cycle that registers raddr_x.
REQ-012 SHALL compare records only on the unsigned field rec[KEY_LSB +: KEY_WIDTH]; all other bits SHALL be carried unchanged with their key.
REQ-013 SHALL, with descending=0, leave addresses 0..N-1 in non-decreasing key order; with descending=1, in non-increasing key order. The heap is a max-heap for ascending and a min-heap for descending.
REQ-014 SHALL NOT swap on equal keys; stability is not required.
REQ-015 SHALL implement states IDLE, BUILD, SIFT_RD, SIFT_WAIT, SIFT_CMP, SIFT_WR, EXTRACT_RD, EXTRACT_WAIT, EXTRACT_WR, FINISH.
REQ-016 IDLE: on start with busy=0, latch N=num_values and descending, and assert busy next cycle. If N<=1, go to FINISH; otherwise set build index to N/2-1 and go to BUILD. Start while busy SHALL be ignored.
REQ-017 SIFT_RD: read node on port A, left child 2i+1 on port B; right child 2i+2 SHALL be read the following cycle on port A, only if it is below the heap size.
REQ-018 SIFT_CMP: select the preferred child (larger key when ascending, smaller when descending; left wins ties) and swap only if it is strictly preferred over the node. If no child exists or no swap is needed, sift ends.
REQ-019 SIFT_WR: perform the swap in one cycle, port A writing the child record to the node address and port B writing the node record to the child address. Sift then continues at the child index.
REQ-020 BUILD: sift each index from N/2-1 down to 0, then enter the extract phase with heap size N.
REQ-021 Extract: while heap size > 1, read addresses 0 and size-1, then write them swapped in one cycle using both ports, decrement size, and sift from 0. When size reaches 1, go to FINISH.
REQ-022 FINISH: pulse done for exactly one cycle, deassert busy in the same cycle, then return to IDLE.
REQ-023 progress SHALL equal the current heap size during extract, N during build, and 0 in IDLE.
REQ-024 abort while busy SHALL take effect on the next edge: write enables low, busy low, aborted pulses for one cycle, state IDLE. RAM contents are then undefined but contain only original records. Abort in IDLE SHALL be ignored.
REQ-025 SHALL never assert we_a and we_b to the same address in one cycle; port A and port B SHALL NOT read an address written in the same cycle.
REQ-026 Write enables SHALL be single-cycle and default low in every state except SIFT_WR and EXTRACT_WR.
REQ-027 Child index arithmetic SHALL be DATA_ADDR_BITS+2 bits wide so that 2i+2 does not overflow for N=2^DATA_ADDR_BITS.
REQ-028 num_values greater than 2^DATA_ADDR_BITS SHALL be clamped to 2^DATA_ADDR_BITS.

Reset
REQ-029 On rst: state IDLE, busy=0, done=0, aborted=0, we_a=0, we_b=0, progress=0; all addresses and write data SHALL be 0.
REQ-030 rst SHALL override start and abort in the same cycle, and reset mid-sort SHALL stop all writes from the next cycle.

Verification
REQ-031 Scenario: N=8, keys {5,3,8,1,9,2,7,4}, descending=0 -> RAM holds {1,2,3,4,5,7,8,9}; done pulses once; busy falls in the same cycle.
REQ-032 Scenario: same data, descending=1 -> {9,8,7,5,4,3,2,1}; payload bits outside the key travel with their key (KEY_LSB=32, distinct payloads checked).
REQ-033 Scenario: N=0 and N=1 -> no writes; done pulses 2 cycles after start; RAM unchanged.
REQ-034 Scenario: N=2^DATA_ADDR_BITS (DATA_ADDR_BITS=4, 16 records) of random keys with duplicates -> sorted output, multiset preserved, no same-address dual write.
REQ-035 Scenario: abort 50 cycles after start -> aborted pulse, busy=0, no further writes; a new start then sorts correctly.
REQ-036 Scenario: rst asserted mid-extract -> all outputs at reset values next cycle; start asserted during busy is ignored and produces exactly one done.

Source files
------------

// File: rtl/keyed_heap_sorter.sv
// In-place heapsort engine that works over an external dual-port RAM with synchronous reads.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   start, num_values         begin a sort of num_values records (clamped to 2^DATA_ADDR_BITS)
//   descending                order select, sampled at start
//   abort                     cancel the sort in progress
//   we_x/waddr_x/wdata_x      RAM write port x (x = a, b), one-cycle write strobes
//   raddr_x/rdata_x           RAM read port x; rdata is valid two cycles after raddr is registered
//   busy, done, aborted       status; done and aborted are single-cycle pulses
//   progress                  current heap size (N while building, 0 when idle)
module keyed_heap_sorter #(
  parameter int unsigned DATA_ADDR_BITS = 13,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned KEY_LSB        = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_ADDR_BITS:0]   num_values,
  input  logic                      descending,
  input  logic                      abort,
  output logic                      we_a,
  output logic [DATA_ADDR_BITS-1:0] waddr_a,
  output logic [DATA_WIDTH-1:0]     wdata_a,
  output logic [DATA_ADDR_BITS-1:0] raddr_a,
  input  logic [DATA_WIDTH-1:0]     rdata_a,
  output logic                      we_b,
  output logic [DATA_ADDR_BITS-1:0] waddr_b,
  output logic [DATA_WIDTH-1:0]     wdata_b,
  output logic [DATA_ADDR_BITS-1:0] raddr_b,
  input  logic [DATA_WIDTH-1:0]     rdata_b,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic [DATA_ADDR_BITS:0]   progress
);

  localparam int unsigned AW = DATA_ADDR_BITS;
  localparam int unsigned SW = DATA_ADDR_BITS + 1;
  localparam int unsigned CW = DATA_ADDR_BITS + 2;
  localparam logic [SW-1:0] MAX_N = {1'b1, {AW{1'b0}}};

  typedef enum logic [3:0] {
    IDLE, BUILD, SIFT_RD, SIFT_WAIT, SIFT_CMP, SIFT_WR,
    EXTRACT_RD, EXTRACT_WAIT, EXTRACT_WR, FINISH
  } state_t;

  state_t          state, state_n;
  logic            desc_q, desc_n;
  logic            extract_q, extract_n;
  logic            phase_q, phase_n;
  logic [SW-1:0]   size_q, size_n;
  logic [SW-1:0]   bcnt_q, bcnt_n;
  logic [AW-1:0]   node_q, node_n;
  logic [AW-1:0]   child_q, child_n;
  logic [DATA_WIDTH-1:0] node_rec_q, node_rec_n;
  logic [DATA_WIDTH-1:0] left_rec_q, left_rec_n;

  logic            we_a_n, we_b_n, busy_n, done_n, aborted_n;
  logic [AW-1:0]   waddr_a_n, waddr_b_n, raddr_a_n, raddr_b_n;
  logic [DATA_WIDTH-1:0] wdata_a_n, wdata_b_n;
  logic [SW-1:0]   progress_n;

  logic [CW-1:0]   left_idx, right_idx;
  logic            has_left, has_right, take_right, do_swap;
  logic [SW-1:0]   n_clamp;
  logic [DATA_WIDTH-1:0] cmp_node, cmp_left, pick_rec;
  logic [AW-1:0]   pick_idx;

  // True when key x belongs closer to the heap root than key y (strict, so ties never swap).
  function automatic logic prefer(input logic desc, input logic [KEY_WIDTH-1:0] x,
                                  input logic [KEY_WIDTH-1:0] y);
    return desc ? (x < y) : (x > y);
  endfunction

  // An address distinct from both written addresses (lo < hi), parked on the read ports during writes.
  function automatic logic [AW-1:0] free_addr(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    if (hi != {AW{1'b1}}) return hi + AW'(1);
    else if (lo != '0)    return '0;
    else                  return AW'(1);
  endfunction

  // Child indices are kept two bits wider than addresses so 2i+2 never wraps.
  assign left_idx  = {1'b0, node_q, 1'b1};
  assign right_idx = left_idx + CW'(1);
  assign has_left  = left_idx  < CW'(size_q);
  assign has_right = right_idx < CW'(size_q);
  assign n_clamp   = (num_values > MAX_N) ? MAX_N : num_values;

  // Node/left come straight from the RAM in the first compare cycle, from holding regs in the second.
  always_comb begin
    cmp_node   = phase_q ? node_rec_q : rdata_a;
    cmp_left   = phase_q ? left_rec_q : rdata_b;
    take_right = has_right && phase_q &&
                 prefer(desc_q, rdata_a[KEY_LSB +: KEY_WIDTH], cmp_left[KEY_LSB +: KEY_WIDTH]);
    pick_rec   = take_right ? rdata_a : cmp_left;
    pick_idx   = take_right ? AW'(right_idx) : AW'(left_idx);
    do_swap    = prefer(desc_q, pick_rec[KEY_LSB +: KEY_WIDTH], cmp_node[KEY_LSB +: KEY_WIDTH]);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    desc_n     = desc_q;
    extract_n  = extract_q;
    phase_n    = 1'b0;
    size_n     = size_q;
    bcnt_n     = bcnt_q;
    node_n     = node_q;
    child_n    = child_q;
    node_rec_n = node_rec_q;
    left_rec_n = left_rec_q;
    we_a_n     = 1'b0;
    we_b_n     = 1'b0;
    waddr_a_n  = waddr_a;
    waddr_b_n  = waddr_b;
    wdata_a_n  = wdata_a;
    wdata_b_n  = wdata_b;
    raddr_a_n  = raddr_a;
    raddr_b_n  = raddr_b;
    busy_n     = busy;
    done_n     = 1'b0;
    aborted_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start && !busy) begin
          size_n    = n_clamp;
          desc_n    = descending;
          extract_n = 1'b0;
          busy_n    = 1'b1;
          if (n_clamp <= SW'(1)) begin
            state_n = FINISH;
          end else begin
            bcnt_n  = n_clamp >> 1;
            state_n = BUILD;
          end
        end
      end
      // bcnt counts the build indices still to sift; index sifted is bcnt-1.
      BUILD: begin
        if (bcnt_q == '0) begin
          extract_n = 1'b1;
          state_n   = EXTRACT_RD;
        end else begin
          node_n  = AW'(bcnt_q - SW'(1));
          bcnt_n  = bcnt_q - SW'(1);
          state_n = SIFT_RD;
        end
      end
      SIFT_RD: begin
        raddr_a_n = node_q;
        raddr_b_n = AW'(left_idx);
        state_n   = SIFT_WAIT;
      end
      SIFT_WAIT: begin
        if (has_right) raddr_a_n = AW'(right_idx);
        state_n = SIFT_CMP;
      end
      SIFT_CMP: begin
        if (!phase_q) begin
          node_rec_n = rdata_a;
          left_rec_n = rdata_b;
        end
        if (!has_left) begin
          state_n = extract_q ? EXTRACT_RD : BUILD;
        end else if (has_right && !phase_q) begin
          phase_n = 1'b1;  // right child lands on port A one cycle later
        end else if (do_swap) begin
          we_a_n    = 1'b1;
          waddr_a_n = node_q;
          wdata_a_n = pick_rec;
          we_b_n    = 1'b1;
          waddr_b_n = pick_idx;
          wdata_b_n = cmp_node;
          raddr_a_n = free_addr(node_q, pick_idx);
          raddr_b_n = free_addr(node_q, pick_idx);
          child_n   = pick_idx;
          state_n   = SIFT_WR;
        end else begin
          state_n = extract_q ? EXTRACT_RD : BUILD;
        end
      end
      SIFT_WR: begin
        node_n  = child_q;
        state_n = SIFT_RD;
      end
      EXTRACT_RD: begin
        if (size_q <= SW'(1)) begin
          state_n = FINISH;
        end else begin
          raddr_a_n = '0;
          raddr_b_n = AW'(size_q - SW'(1));
          state_n   = EXTRACT_WAIT;
        end
      end
      EXTRACT_WAIT: begin
        if (!phase_q) begin
          phase_n = 1'b1;
        end else begin
          we_a_n    = 1'b1;
          waddr_a_n = '0;
          wdata_a_n = rdata_b;
          we_b_n    = 1'b1;
          waddr_b_n = AW'(size_q - SW'(1));
          wdata_b_n = rdata_a;
          raddr_a_n = free_addr('0, AW'(size_q - SW'(1)));
          raddr_b_n = free_addr('0, AW'(size_q - SW'(1)));
          state_n   = EXTRACT_WR;
        end
      end
      EXTRACT_WR: begin
        size_n = size_q - SW'(1);
        if (size_q == SW'(2)) begin
          state_n = FINISH;
        end else begin
          node_n  = '0;
          state_n = SIFT_RD;
        end
      end
      FINISH: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (abort && busy) begin
      state_n   = IDLE;
      we_a_n    = 1'b0;
      we_b_n    = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      aborted_n = 1'b1;
    end

    progress_n = (state_n == IDLE) ? '0 : size_n;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      desc_q     <= 1'b0;
      extract_q  <= 1'b0;
      phase_q    <= 1'b0;
      size_q     <= '0;
      bcnt_q     <= '0;
      node_q     <= '0;
      child_q    <= '0;
      node_rec_q <= '0;
      left_rec_q <= '0;
      we_a       <= 1'b0;
      we_b       <= 1'b0;
      waddr_a    <= '0;
      waddr_b    <= '0;
      wdata_a    <= '0;
      wdata_b    <= '0;
      raddr_a    <= '0;
      raddr_b    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      progress   <= '0;
    end else begin
      state      <= state_n;
      desc_q     <= desc_n;
      extract_q  <= extract_n;
      phase_q    <= phase_n;
      size_q     <= size_n;
      bcnt_q     <= bcnt_n;
      node_q     <= node_n;
      child_q    <= child_n;
      node_rec_q <= node_rec_n;
      left_rec_q <= left_rec_n;
      we_a       <= we_a_n;
      we_b       <= we_b_n;
      waddr_a    <= waddr_a_n;
      waddr_b    <= waddr_b_n;
      wdata_a    <= wdata_a_n;
      wdata_b    <= wdata_b_n;
      raddr_a    <= raddr_a_n;
      raddr_b    <= raddr_b_n;
      busy       <= busy_n;
      done       <= done_n;
      aborted    <= aborted_n;
      progress   <= progress_n;
    end
  end

endmodule

// File: tb/tb_keyed_heap_sorter.sv
// Self-checking bench for keyed_heap_sorter: 16-record RAM, 32-bit key in the upper half of each record.
module tb_keyed_heap_sorter;
  localparam int unsigned AB   = 4;
  localparam int unsigned DW   = 64;
  localparam int unsigned KW   = 32;
  localparam int unsigned KL   = 32;
  localparam int unsigned NMAX = 16;
  localparam int unsigned NVW  = AB + 1;
  localparam int          BUDGET = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, descending = 1'b0, abort = 1'b0;
  logic [AB:0] num_values = '0;
  logic we_a, we_b;
  logic [AB-1:0] waddr_a, raddr_a, waddr_b, raddr_b;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic busy, done, aborted;
  logic [AB:0] progress;

  keyed_heap_sorter #(.DATA_ADDR_BITS(AB), .DATA_WIDTH(DW), .KEY_WIDTH(KW), .KEY_LSB(KL)) dut (
    .clk(clk), .rst(rst), .start(start), .num_values(num_values), .descending(descending),
    .abort(abort),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .busy(busy), .done(done), .aborted(aborted), .progress(progress)
  );

  always #5 clk = ~clk;

  // RAM model plus bus monitors.
  logic [DW-1:0] mem [NMAX];
  logic [DW-1:0] load_img [NMAX];
  logic [DW-1:0] img [NMAX];
  logic load_en = 1'b0;
  int wr_cnt = 0, done_cnt = 0, dual_viol = 0, rw_viol = 0;

  always @(posedge clk) begin
    if (load_en) mem <= load_img;
    else begin
      if (we_a) mem[waddr_a] <= wdata_a;
      if (we_b) mem[waddr_b] <= wdata_b;
    end
    rdata_a  <= mem[raddr_a];
    rdata_b  <= mem[raddr_b];
    wr_cnt   <= wr_cnt + int'(we_a) + int'(we_b);
    done_cnt <= done_cnt + int'(done);
    if (we_a && we_b && waddr_a == waddr_b) dual_viol <= dual_viol + 1;
    if ((we_a && (raddr_a == waddr_a || raddr_b == waddr_a)) ||
        (we_b && (raddr_a == waddr_b || raddr_b == waddr_b))) rw_viol <= rw_viol + 1;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic load_ram();
    @(negedge clk);
    load_img = img;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic rand_img();
    logic [KW-1:0] k;
    for (int i = 0; i < NMAX; i++) begin
      k = ($urandom_range(0, 3) == 0) ? KW'($urandom()) : KW'($urandom_range(0, 5));
      img[i] = {k, 32'hC0DE_0000 | 32'(i)};
    end
  endtask

  // Start a sort and wait (bounded) for done; lat = cycles from the start edge to done.
  task automatic run_sort(input int n, input bit desc, input string tag, output int lat);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    num_values = NVW'(n);
    descending = desc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    if (n >= 2) begin
      check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
      check({tag, "_progress_build"}, 64'(progress), 64'((n > 16) ? 16 : n));
    end
    while (!done && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1));
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'(0));
    check({tag, "_progress_idle"}, 64'(progress), 64'(0));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'(1));
  endtask

  // Record multiset over 0..n-1 preserved and addresses at or above n untouched.
  task automatic check_records(input int n, input string tag);
    logic [DW-1:0] qa[$], qb[$];
    int bad, moved;
    bad = 0;
    moved = 0;
    for (int i = 0; i < n; i++) begin
      qa.push_back(img[i]);
      qb.push_back(mem[i]);
    end
    qa.sort();
    qb.sort();
    for (int i = 0; i < n; i++) if (qa[i] !== qb[i]) bad++;
    for (int i = n; i < NMAX; i++) if (mem[i] !== img[i]) moved++;
    check({tag, "_multiset"}, 64'(bad), 64'(0));
    check({tag, "_untouched"}, 64'(moved), 64'(0));
  endtask

  // Reference: sorted key list of the original image, compared address by address.
  task automatic verify_model(input int n, input bit desc, input string tag);
    logic [KW-1:0] kq[$];
    for (int i = 0; i < n; i++) kq.push_back(img[i][KL +: KW]);
    if (desc) kq.rsort();
    else kq.sort();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_key%0d", tag, i), 64'(mem[i][KL +: KW]), 64'(kq[i]));
    check_records(n, tag);
  endtask

  typedef struct {
    int          n;
    bit          desc;
    logic [63:0] keys;  // nibble i (from the left) is the key at address i
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int lat, n_eff, w0, d0, cyc, bad;
    logic [63:0] kv, ev;
    logic [KW-1:0] k;
    bit found;

    vecs[0]  = '{8,  1'b0, 64'h5381_9274_0000_0000, 64'h1234_5789_0000_0000};
    vecs[1]  = '{8,  1'b1, 64'h5381_9274_0000_0000, 64'h9875_4321_0000_0000};
    vecs[2]  = '{2,  1'b0, 64'h7300_0000_0000_0000, 64'h3700_0000_0000_0000};
    vecs[3]  = '{3,  1'b1, 64'h1230_0000_0000_0000, 64'h3210_0000_0000_0000};
    vecs[4]  = '{5,  1'b0, 64'h4414_4000_0000_0000, 64'h1444_4000_0000_0000};
    vecs[5]  = '{16, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    vecs[6]  = '{7,  1'b1, 64'h0A0A_0A00_0000_0000, 64'hAAA0_0000_0000_0000};
    vecs[7]  = '{31, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    vecs[8]  = '{1,  1'b0, 64'h9000_0000_0000_0000, 64'h9000_0000_0000_0000};
    vecs[9]  = '{0,  1'b0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    vecs[10] = '{16, 1'b1, 64'h5555_5555_5555_5550, 64'h5555_5555_5555_5550};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_aborted", 64'(aborted), 64'(0));
    check("rst_we", 64'({we_a, we_b}), 64'(0));
    check("rst_progress", 64'(progress), 64'(0));
    check("rst_addr", 64'({waddr_a, waddr_b, raddr_a, raddr_b}), 64'(0));
    check("rst_wdata", wdata_a | wdata_b, 64'(0));
    rst = 1'b0;

    // Directed vector table.
    for (int v = 0; v < NV; v++) begin
      n_eff = (vecs[v].n > 16) ? 16 : vecs[v].n;
      kv = vecs[v].keys;
      ev = vecs[v].exp;
      for (int i = 0; i < NMAX; i++) begin
        k = (i < n_eff) ? KW'(kv[63-4*i -: 4]) : (32'hDEAD_0000 + 32'(i));
        img[i] = {k, 32'hC0DE_0000 | 32'(i)};
      end
      load_ram();
      w0 = wr_cnt;
      run_sort(vecs[v].n, vecs[v].desc, $sformatf("vec%0d", v), lat);
      for (int i = 0; i < n_eff; i++)
        check($sformatf("vec%0d_key%0d", v, i), 64'(mem[i][KL +: KW]), 64'(ev[63-4*i -: 4]));
      check_records(n_eff, $sformatf("vec%0d", v));
      if (n_eff <= 1) begin
        check($sformatf("vec%0d_latency", v), 64'(lat), 64'(2));
        check($sformatf("vec%0d_no_writes", v), 64'(wr_cnt - w0), 64'(0));
      end
    end

    // Random images against the reference model.
    for (int r = 0; r < 6; r++) begin
      int n;
      bit d;
      n = (r < 2) ? 16 : $urandom_range(2, 16);
      d = (r == 1) ? 1'b1 : ((r == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      rand_img();
      load_ram();
      run_sort(n, d, $sformatf("rnd%0d", r), lat);
      verify_model(n, d, $sformatf("rnd%0d", r));
    end

    // Abort 50 cycles after start.
    rand_img();
    load_ram();
    @(negedge clk);
    num_values = NVW'(16);
    descending = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pulse", 64'(aborted), 64'(1));
    check("abort_busy_low", 64'(busy), 64'(0));
    check("abort_we_low", 64'({we_a, we_b}), 64'(0));
    w0 = wr_cnt;
    @(negedge clk);
    check("abort_pulse_one_cycle", 64'(aborted), 64'(0));
    repeat (10) @(negedge clk);
    check("abort_no_writes", 64'(wr_cnt - w0), 64'(0));
    bad = 0;
    for (int i = 0; i < NMAX; i++) begin
      found = 1'b0;
      for (int j = 0; j < NMAX; j++) if (mem[i] === img[j]) found = 1'b1;
      if (!found) bad++;
    end
    check("abort_only_original", 64'(bad), 64'(0));
    img = mem;
    run_sort(16, 1'b1, "post_abort", lat);
    verify_model(16, 1'b1, "post_abort");

    // Reset mid-extract, with start and abort asserted alongside it.
    rand_img();
    load_ram();
    @(negedge clk);
    num_values = NVW'(16);
    descending = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(busy && progress <= NVW'(12)) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached_extract", 64'(busy && progress <= NVW'(12)), 64'(1));
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_done_aborted", 64'({done, aborted}), 64'(0));
    check("rst_mid_we", 64'({we_a, we_b}), 64'(0));
    check("rst_mid_progress", 64'(progress), 64'(0));
    check("rst_mid_addr", 64'({waddr_a, waddr_b, raddr_a, raddr_b}), 64'(0));
    check("rst_mid_wdata", wdata_a | wdata_b, 64'(0));
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    check("rst_mid_no_writes", 64'(wr_cnt - w0), 64'(0));
    check("rst_mid_stays_idle", 64'(busy), 64'(0));

    // Start while busy is ignored: one done, result from the first request.
    rand_img();
    load_ram();
    d0 = done_cnt;
    @(negedge clk);
    num_values = NVW'(12);
    descending = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("restart_busy", 64'(busy), 64'(1));
    num_values = NVW'(16);
    descending = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("restart_done_seen", 64'(done), 64'(1));
    repeat (30) @(negedge clk);
    check("restart_one_done", 64'(done_cnt - d0), 64'(1));
    verify_model(12, 1'b1, "restart");

    check("dual_write_same_addr", 64'(dual_viol), 64'(0));
    check("read_of_written_addr", 64'(rw_viol), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
